// File: rtl/toe_init_host.sv
// toe_init_host: Avalon-MM host that programs one TCP offload engine connection.
// A command loads the connection parameters into the engine, optionally issues a
// request code, polls the engine's done flag, then reads back error and id.
// Optional poll timeout: define TOE_INIT_HOST_TIMEOUT_EN to bound polling at
// MAX_POLLS samples, after which the request is cancelled.
module toe_init_host #(
  parameter int unsigned POLL_GAP  = 2,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_code,
  input  logic [31:0] cmd_ip_src,
  input  logic [31:0] cmd_ip_dst,
  input  logic [23:0] cmd_mac_src,
  input  logic [23:0] cmd_mac_dst,
  input  logic [15:0] cmd_port_src,
  input  logic [15:0] cmd_port_dst,
  input  logic [7:0]  cmd_id,
  output logic        rsp_valid,
  output logic [7:0]  rsp_error,
  output logic [7:0]  rsp_id,
  output logic        rsp_timeout,
  output logic [3:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write,
  output logic        av_read,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata
);

  // Engine register map
  localparam logic [3:0] AddrReq     = 4'h0;
  localparam logic [3:0] AddrDone    = 4'h1;
  localparam logic [3:0] AddrErr     = 4'h2;
  localparam logic [3:0] AddrIpSrc   = 4'h3;
  localparam logic [3:0] AddrIpDst   = 4'h4;
  localparam logic [3:0] AddrMacSrc  = 4'h5;
  localparam logic [3:0] AddrMacDst  = 4'h6;
  localparam logic [3:0] AddrPortSrc = 4'h7;
  localparam logic [3:0] AddrPortDst = 4'h8;
  localparam logic [3:0] AddrIdIn    = 4'h9;
  localparam logic [3:0] AddrIdOut   = 4'hA;

  // Gap counter runs 0..POLL_GAP-1; it is never entered when POLL_GAP is 0.
  localparam int unsigned GapLast = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;
  localparam int unsigned GapW    = (GapLast > 0) ? $clog2(GapLast + 1) : 1;

  localparam logic [2:0] ParamLast = 3'd6;

  typedef enum logic [3:0] {
    StIdle,
    StWrParam,
    StWrReq,
    StPollRd,
    StPollCap,
    StGap,
    StErrRd,
    StErrCap,
    StIdRd,
    StIdCap,
    StClrDone,
    StCancel,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        par_idx_q, par_idx_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]        err_cap_q, err_cap_d;
  logic [7:0]        id_cap_q, id_cap_d;
  logic [7:0]        rsp_error_q, rsp_error_d;
  logic [7:0]        rsp_id_q, rsp_id_d;
  logic              load_cmd;

  // Command snapshot, frozen from accept until the next IDLE
  logic [1:0]        code_q;
  logic [31:0]       ip_src_q, ip_dst_q;
  logic [23:0]       mac_src_q, mac_dst_q;
  logic [15:0]       port_src_q, port_dst_q;
  logic [7:0]        id_q;

  logic [3:0]        param_addr;
  logic [31:0]       param_data;

`ifdef TOE_INIT_HOST_TIMEOUT_EN
  localparam int unsigned PollLast = (MAX_POLLS == 0) ? 0 : MAX_POLLS - 1;
  localparam int unsigned PollW    = (PollLast > 0) ? $clog2(PollLast + 1) : 1;

  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // Poll counter and timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      poll_cnt_q    <= poll_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  // Polling is unbounded without the timeout feature.
  logic unused_max_polls;
  assign unused_max_polls = (MAX_POLLS == 0);
  assign rsp_timeout      = 1'b0;
`endif

  // Only the done bit and the low byte of read data carry information.
  logic unused_readdata;
  assign unused_readdata = ^av_readdata[31:8];

  // Capture the command fields on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q     <= '0;
      ip_src_q   <= '0;
      ip_dst_q   <= '0;
      mac_src_q  <= '0;
      mac_dst_q  <= '0;
      port_src_q <= '0;
      port_dst_q <= '0;
      id_q       <= '0;
    end else if (load_cmd) begin
      code_q     <= cmd_code;
      ip_src_q   <= cmd_ip_src;
      ip_dst_q   <= cmd_ip_dst;
      mac_src_q  <= cmd_mac_src;
      mac_dst_q  <= cmd_mac_dst;
      port_src_q <= cmd_port_src;
      port_dst_q <= cmd_port_dst;
      id_q       <= cmd_id;
    end
  end

  // State register, sequencing counters and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      par_idx_q   <= '0;
      gap_cnt_q   <= '0;
      err_cap_q   <= '0;
      id_cap_q    <= '0;
      rsp_error_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      par_idx_q   <= par_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      err_cap_q   <= err_cap_d;
      id_cap_q    <= id_cap_d;
      rsp_error_q <= rsp_error_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Parameter write sequence: address and zero-extended data per step
  always_comb begin
    param_addr = AddrIpSrc;
    param_data = '0;
    unique case (par_idx_q)
      3'd0: begin param_addr = AddrIpSrc;   param_data = ip_src_q;              end
      3'd1: begin param_addr = AddrIpDst;   param_data = ip_dst_q;              end
      3'd2: begin param_addr = AddrMacSrc;  param_data = {8'h00, mac_src_q};    end
      3'd3: begin param_addr = AddrMacDst;  param_data = {8'h00, mac_dst_q};    end
      3'd4: begin param_addr = AddrPortSrc; param_data = {16'h0000, port_src_q}; end
      3'd5: begin param_addr = AddrPortDst; param_data = {16'h0000, port_dst_q}; end
      3'd6: begin param_addr = AddrIdOut;   param_data = {24'h000000, id_q};    end
      default: ;
    endcase
  end

  // Next-state logic and Avalon-MM strobes
  always_comb begin
    state_d       = state_q;
    par_idx_d     = par_idx_q;
    gap_cnt_d     = gap_cnt_q;
    err_cap_d     = err_cap_q;
    id_cap_d      = id_cap_q;
    rsp_error_d   = rsp_error_q;
    rsp_id_d      = rsp_id_q;
`ifdef TOE_INIT_HOST_TIMEOUT_EN
    poll_cnt_d    = poll_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    load_cmd      = 1'b0;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    av_chipselect = 1'b0;
    av_write      = 1'b0;
    av_read       = 1'b0;
    av_address    = '0;
    av_writedata  = '0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load_cmd  = 1'b1;
          par_idx_d = '0;
          state_d   = StWrParam;
`ifdef TOE_INIT_HOST_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end

      StWrParam: begin
        av_chipselect = 1'b1;
        av_write      = 1'b1;
        av_address    = param_addr;
        av_writedata  = param_data;
        if (par_idx_q == ParamLast) begin
          par_idx_d = '0;
          if (code_q == 2'd0) begin
            // Load-only command: respond without touching the request register.
            state_d     = StResp;
            rsp_error_d = '0;
            rsp_id_d    = '0;
`ifdef TOE_INIT_HOST_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
          end else begin
            state_d = StWrReq;
          end
        end else begin
          par_idx_d = par_idx_q + 3'd1;
        end
      end

      StWrReq: begin
        av_chipselect = 1'b1;
        av_write      = 1'b1;
        av_address    = AddrReq;
        av_writedata  = {30'h0, code_q};
        state_d       = StPollRd;
      end

      StPollRd: begin
        av_chipselect = 1'b1;
        av_read       = 1'b1;
        av_address    = AddrDone;
        state_d       = StPollCap;
      end

      StPollCap: begin
        if (av_readdata[0]) begin
          state_d = StErrRd;
        end else begin
          gap_cnt_d = '0;
          state_d   = (POLL_GAP == 0) ? StPollRd : StGap;
`ifdef TOE_INIT_HOST_TIMEOUT_EN
          if (poll_cnt_q == PollW'(PollLast)) begin
            state_d = StCancel;
          end else begin
            poll_cnt_d = poll_cnt_q + PollW'(1);
          end
`endif
        end
      end

      StGap: begin
        if (gap_cnt_q == GapW'(GapLast)) begin
          state_d = StPollRd;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end

      StErrRd: begin
        av_chipselect = 1'b1;
        av_read       = 1'b1;
        av_address    = AddrErr;
        state_d       = StErrCap;
      end

      StErrCap: begin
        err_cap_d = av_readdata[7:0];
        state_d   = StIdRd;
      end

      StIdRd: begin
        av_chipselect = 1'b1;
        av_read       = 1'b1;
        av_address    = AddrIdIn;
        state_d       = StIdCap;
      end

      StIdCap: begin
        id_cap_d = av_readdata[7:0];
        state_d  = StClrDone;
      end

      StClrDone: begin
        av_chipselect = 1'b1;
        av_write      = 1'b1;
        av_address    = AddrDone;
        av_writedata  = '0;
        state_d       = StResp;
        rsp_error_d   = err_cap_q;
        rsp_id_d      = id_cap_q;
`ifdef TOE_INIT_HOST_TIMEOUT_EN
        rsp_timeout_d = 1'b0;
`endif
      end

      StCancel: begin
        // Withdraw the request after too many unanswered polls.
        av_chipselect = 1'b1;
        av_write      = 1'b1;
        av_address    = AddrReq;
        av_writedata  = '0;
        state_d       = StResp;
        rsp_error_d   = '0;
        rsp_id_d      = '0;
`ifdef TOE_INIT_HOST_TIMEOUT_EN
        rsp_timeout_d = 1'b1;
`endif
      end

      StResp: begin
        rsp_valid = 1'b1;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign rsp_error = rsp_error_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_toe_init_host.sv
// tb_toe_init_host: randomized self-checking bench for toe_init_host with a
// behavioural engine slave and a transaction-level expectation model.
module tb_toe_init_host;

  localparam int unsigned GAP  = 2;
  localparam int unsigned MAXP = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_code;
  logic [31:0] cmd_ip_src, cmd_ip_dst;
  logic [23:0] cmd_mac_src, cmd_mac_dst;
  logic [15:0] cmd_port_src, cmd_port_dst;
  logic [7:0]  cmd_id;
  logic        rsp_valid;
  logic [7:0]  rsp_error, rsp_id;
  logic        rsp_timeout;
  logic [3:0]  av_address;
  logic        av_chipselect, av_write, av_read;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;

  toe_init_host #(
    .POLL_GAP (GAP),
    .MAX_POLLS(MAXP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_code     (cmd_code),
    .cmd_ip_src   (cmd_ip_src),
    .cmd_ip_dst   (cmd_ip_dst),
    .cmd_mac_src  (cmd_mac_src),
    .cmd_mac_dst  (cmd_mac_dst),
    .cmd_port_src (cmd_port_src),
    .cmd_port_dst (cmd_port_dst),
    .cmd_id       (cmd_id),
    .rsp_valid    (rsp_valid),
    .rsp_error    (rsp_error),
    .rsp_id       (rsp_id),
    .rsp_timeout  (rsp_timeout),
    .av_address   (av_address),
    .av_chipselect(av_chipselect),
    .av_write     (av_write),
    .av_read      (av_read),
    .av_writedata (av_writedata),
    .av_readdata  (av_readdata)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  // Slave behaviour and observation log
  int unsigned done_on_poll = 1;  // 0: done never set
  logic [7:0]  sl_err = 8'h00;
  logic [7:0]  sl_id  = 8'h00;
  int unsigned poll_seen = 0;
  logic        rd_pend = 1'b0;
  logic [3:0]  rd_pend_addr = 4'h0;
  int          proto_err = 0;
  int unsigned wr_a[$], wr_d[$], wr_c[$], rd_a[$], rd_c[$], rsp_c[$];
  logic [7:0]  rsp_e_seen, rsp_i_seen;
  logic        rsp_t_seen, rsp_rdy;
  int unsigned acc_cyc = 0;
  bit          acc_ok = 0;

  // Model output
  string       exp_wr, exp_rd;
  int          exp_rsp;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine slave: read data valid one cycle after the read; logs all bus traffic.
  always @(negedge clk) begin
    logic [31:0] r;
    r = $urandom;
    if (rd_pend) begin
      if (rd_pend_addr == 4'h1) begin
        poll_seen++;
        r[0] = (done_on_poll != 0) && (poll_seen >= done_on_poll);
      end else if (rd_pend_addr == 4'h2) begin
        r[7:0] = sl_err;
      end else if (rd_pend_addr == 4'h9) begin
        r[7:0] = sl_id;
      end
    end
    av_readdata  = r;
    rd_pend      = av_read;
    rd_pend_addr = av_address;
    if (av_write && av_read) proto_err++;
    if ((av_write || av_read) && !av_chipselect) proto_err++;
    if (av_write) begin
      wr_a.push_back(av_address); wr_d.push_back(av_writedata); wr_c.push_back(cyc);
    end
    if (av_read) begin
      rd_a.push_back(av_address); rd_c.push_back(cyc);
    end
    if (rsp_valid) begin
      rsp_c.push_back(cyc);
      rsp_e_seen = rsp_error; rsp_i_seen = rsp_id; rsp_t_seen = rsp_timeout;
      rsp_rdy    = cmd_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    rd_a.delete(); rd_c.delete(); rsp_c.delete();
    poll_seen = 0;
  endtask

  function automatic string obs_wr();
    string s = "";
    foreach (wr_a[i])
      s = {s, $sformatf("%0h:%0h@%0d ", wr_a[i], wr_d[i], int'(wr_c[i]) - int'(acc_cyc))};
    return s;
  endfunction

  function automatic string obs_rd();
    string s = "";
    foreach (rd_a[i]) s = {s, $sformatf("%0h@%0d ", rd_a[i], int'(rd_c[i]) - int'(acc_cyc))};
    return s;
  endfunction

  function automatic int obs_rsp();
    return (rsp_c.size() > 0) ? int'(rsp_c[0]) - int'(acc_cyc) : -1;
  endfunction

  // Expected bus trace and response time, relative to the accept cycle.
  task automatic model(input logic [1:0] code, input logic [31:0] ips, ipd,
                       input logic [23:0] ms, md, input logic [15:0] ps, pd,
                       input logic [7:0] id, input int npoll, input bit tmo);
    int unsigned a[7];
    int unsigned d[7];
    int last;
    a = '{3, 4, 5, 6, 7, 8, 10};
    d[0] = ips; d[1] = ipd; d[2] = 32'(ms); d[3] = 32'(md);
    d[4] = 32'(ps); d[5] = 32'(pd); d[6] = 32'(id);
    exp_wr = ""; exp_rd = "";
    for (int i = 0; i < 7; i++) exp_wr = {exp_wr, $sformatf("%0h:%0h@%0d ", a[i], d[i], i + 1)};
    if (code == 2'd0) begin
      exp_rsp = 8;
      return;
    end
    exp_wr = {exp_wr, $sformatf("0:%0h@8 ", code)};
    for (int k = 0; k < npoll; k++) exp_rd = {exp_rd, $sformatf("1@%0d ", 9 + k * (GAP + 2))};
    last = 9 + (npoll - 1) * (GAP + 2);
    if (tmo) begin
      exp_wr  = {exp_wr, $sformatf("0:0@%0d ", last + 2)};
      exp_rsp = last + 3;
    end else begin
      exp_rd  = {exp_rd, $sformatf("2@%0d 9@%0d ", last + 2, last + 4)};
      exp_wr  = {exp_wr, $sformatf("1:0@%0d ", last + 6)};
      exp_rsp = last + 7;
    end
  endtask

  // Present a command, scramble inputs after accept (unless held), wait for the response.
  task automatic run_cmd(input logic [1:0] code, input logic [31:0] ips, ipd,
                         input logic [23:0] ms, md, input logic [15:0] ps, pd,
                         input logic [7:0] id, input bit hold);
    clear_log();
    acc_ok = 0;
    cmd_code = code; cmd_ip_src = ips; cmd_ip_dst = ipd; cmd_mac_src = ms; cmd_mac_dst = md;
    cmd_port_src = ps; cmd_port_dst = pd; cmd_id = id; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !acc_ok; i++) begin
      if (cmd_ready) begin
        acc_ok = 1; acc_cyc = cyc;
      end
      step();
    end
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_code = 2'($urandom); cmd_ip_src = $urandom; cmd_ip_dst = $urandom;
      cmd_mac_src = 24'($urandom); cmd_mac_dst = 24'($urandom);
      cmd_port_src = 16'($urandom); cmd_port_dst = 16'($urandom); cmd_id = 8'($urandom);
    end
    for (int i = 0; i < 600 && rsp_c.size() == 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    step();
    step();
    checks++;
    if ({av_chipselect, av_write, av_read} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b want 000", {av_chipselect, av_write, av_read});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    checks++;
    if ({av_address, av_writedata} !== 36'h0) begin
      errors++; $display("FAIL reset_bus: got %h/%h want 0/0", av_address, av_writedata);
    end
    checks++;
    if ({rsp_valid, rsp_error, rsp_id, rsp_timeout} !== 18'h0) begin
      errors++;
      $display("FAIL reset_rsp: got v%b e%h i%h t%b want all 0", rsp_valid, rsp_error, rsp_id,
               rsp_timeout);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] ipd = $urandom;
    logic [23:0] ms = 24'($urandom), md = 24'($urandom);
    logic [15:0] ps = 16'($urandom), pd = 16'($urandom);
    done_on_poll = 3; sl_err = 8'h00; sl_id = 8'h2A; proto_err = 0;
    model(2'd1, 32'hC0A80001, ipd, ms, md, ps, pd, 8'h05, 3, 0);
    run_cmd(2'd1, 32'hC0A80001, ipd, ms, md, ps, pd, 8'h05, 0);
    checks++;
    if (obs_wr() != exp_wr) begin
      errors++; $display("FAIL basic_writes: got '%s' want '%s'", obs_wr(), exp_wr);
    end
    checks++;
    if (obs_rd() != exp_rd) begin
      errors++; $display("FAIL basic_reads: got '%s' want '%s'", obs_rd(), exp_rd);
    end
    checks++;
    if (obs_rsp() !== exp_rsp) begin
      errors++; $display("FAIL basic_rsp_time: got %0d want %0d", obs_rsp(), exp_rsp);
    end
    checks++;
    if ({rsp_e_seen, rsp_i_seen, rsp_t_seen} !== {8'h00, 8'h2A, 1'b0}) begin
      errors++;
      $display("FAIL basic_rsp: got e%h i%h t%b want e00 i2a t0", rsp_e_seen, rsp_i_seen,
               rsp_t_seen);
    end
    checks++;
    if (rsp_c.size() !== 1 || proto_err !== 0) begin
      errors++;
      $display("FAIL basic_pulse_proto: got pulses=%0d proto=%0d want 1/0", rsp_c.size(),
               proto_err);
    end
  endtask

  task automatic test_error();
    int seen;
    done_on_poll = 1; sl_err = 8'h7F; sl_id = 8'hFF;
    run_cmd(2'd3, $urandom, $urandom, 24'($urandom), 24'($urandom), 16'($urandom),
            16'($urandom), 8'($urandom), 0);
    checks++;
    if ({rsp_e_seen, rsp_i_seen} !== {8'h7F, 8'hFF}) begin
      errors++; $display("FAIL error_rsp: got e%h i%h want e7f iff", rsp_e_seen, rsp_i_seen);
    end
    seen = (rd_c.size() > 0 && rsp_c.size() > 0) ? int'(rsp_c[0]) - int'(rd_c[0]) - 1 : -1;
    checks++;
    if (seen !== 6) begin
      errors++; $display("FAIL error_done_to_rsp: got %0d want 6", seen);
    end
    step(); step(); step();
    checks++;
    if ({rsp_valid, rsp_error, rsp_id} !== {1'b0, 8'h7F, 8'hFF}) begin
      errors++;
      $display("FAIL error_hold: got v%b e%h i%h want v0 e7f iff", rsp_valid, rsp_error, rsp_id);
    end
  endtask

  task automatic test_reset_gap();
    done_on_poll = 0;
    clear_log();
    cmd_code = 2'd1; cmd_ip_src = $urandom; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !cmd_ready; i++) step();
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && rd_c.size() == 0; i++) step();
    step(); step();
    rst = 1'b1;
    step();
    checks++;
    if ({av_chipselect, av_write, av_read, cmd_ready, rsp_valid} !== 5'b00010) begin
      errors++;
      $display("FAIL gaprst_outputs: got cs/w/r/rdy/v=%b want 00010",
               {av_chipselect, av_write, av_read, cmd_ready, rsp_valid});
    end
    checks++;
    if ({rsp_error, rsp_id, av_address} !== 20'h0) begin
      errors++;
      $display("FAIL gaprst_regs: got e%h i%h a%h want 0", rsp_error, rsp_id, av_address);
    end
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (wr_a.size() + rd_a.size() + rsp_c.size() !== 0) begin
      errors++;
      $display("FAIL gaprst_quiet: got w%0d r%0d rsp%0d want 0", wr_a.size(), rd_a.size(),
               rsp_c.size());
    end
    done_on_poll = 2; sl_err = 8'h11; sl_id = 8'h22;
    model(2'd2, 32'h01020304, 32'h05060708, 24'hABCDEF, 24'h123456, 16'h0050, 16'h1F90, 8'h33,
          2, 0);
    run_cmd(2'd2, 32'h01020304, 32'h05060708, 24'hABCDEF, 24'h123456, 16'h0050, 16'h1F90, 8'h33,
            0);
    checks++;
    if (obs_wr() != exp_wr || obs_rd() != exp_rd) begin
      errors++;
      $display("FAIL gaprst_rerun: got '%s|%s' want '%s|%s'", obs_wr(), obs_rd(), exp_wr,
               exp_rd);
    end
    checks++;
    if (obs_rsp() !== exp_rsp || {rsp_e_seen, rsp_i_seen} !== 16'h1122) begin
      errors++;
      $display("FAIL gaprst_rsp: got t%0d e%h i%h want t%0d e11 i22", obs_rsp(), rsp_e_seen,
               rsp_i_seen, exp_rsp);
    end
  endtask

  task automatic test_load_only();
    logic [31:0] ips = $urandom, ipd = $urandom;
    logic [23:0] ms = 24'($urandom), md = 24'($urandom);
    logic [15:0] ps = 16'($urandom), pd = 16'($urandom);
    logic [7:0] id = 8'($urandom);
    sl_err = 8'h5A; sl_id = 8'hA5; done_on_poll = 1;
    model(2'd0, ips, ipd, ms, md, ps, pd, id, 0, 0);
    run_cmd(2'd0, ips, ipd, ms, md, ps, pd, id, 0);
    checks++;
    if (obs_wr() != exp_wr) begin
      errors++; $display("FAIL load_writes: got '%s' want '%s'", obs_wr(), exp_wr);
    end
    checks++;
    if (rd_a.size() !== 0) begin
      errors++; $display("FAIL load_reads: got %0d reads want 0", rd_a.size());
    end
    checks++;
    if (obs_rsp() !== 8) begin
      errors++; $display("FAIL load_rsp_time: got %0d want 8", obs_rsp());
    end
    checks++;
    if ({rsp_e_seen, rsp_i_seen, rsp_t_seen} !== 17'h0) begin
      errors++;
      $display("FAIL load_rsp: got e%h i%h t%b want 0", rsp_e_seen, rsp_i_seen, rsp_t_seen);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] ips = $urandom;
    int npoll;
    bit tmo;
    sl_err = 8'h44; sl_id = 8'h55; proto_err = 0;
`ifdef TOE_INIT_HOST_TIMEOUT_EN
    done_on_poll = 0; npoll = MAXP; tmo = 1;
`else
    done_on_poll = MAXP + 2; npoll = MAXP + 2; tmo = 0;
`endif
    model(2'd2, ips, 32'h0, 24'h0, 24'h0, 16'h0, 16'h0, 8'h09, npoll, tmo);
    run_cmd(2'd2, ips, 32'h0, 24'h0, 24'h0, 16'h0, 16'h0, 8'h09, 0);
    checks++;
    if (obs_wr() != exp_wr || obs_rd() != exp_rd) begin
      errors++;
      $display("FAIL timeout_trace: got '%s|%s' want '%s|%s'", obs_wr(), obs_rd(), exp_wr,
               exp_rd);
    end
    checks++;
    if (obs_rsp() !== exp_rsp || rsp_t_seen !== tmo) begin
      errors++;
      $display("FAIL timeout_rsp: got t%0d to%b want t%0d to%b", obs_rsp(), rsp_t_seen, exp_rsp,
               tmo);
    end
    checks++;
    if ({rsp_e_seen, rsp_i_seen} !== (tmo ? 16'h0000 : 16'h4455) || proto_err !== 0) begin
      errors++;
      $display("FAIL timeout_vals: got e%h i%h proto=%0d", rsp_e_seen, rsp_i_seen, proto_err);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned r1;
    logic rdy1;
    model(2'd0, 32'hDEADBEEF, 32'h0, 24'h1, 24'h2, 16'h3, 16'h4, 8'h77, 0, 0);
    run_cmd(2'd0, 32'hDEADBEEF, 32'h0, 24'h1, 24'h2, 16'h3, 16'h4, 8'h77, 1);
    r1   = (rsp_c.size() > 0) ? rsp_c[0] : 0;
    rdy1 = rsp_rdy;
    checks++;
    if (rdy1 !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_in_resp: got %b want 0", rdy1);
    end
    run_cmd(2'd0, 32'hDEADBEEF, 32'h0, 24'h1, 24'h2, 16'h3, 16'h4, 8'h77, 0);
    checks++;
    if (acc_cyc !== r1 + 1) begin
      errors++; $display("FAIL b2b_accept: got cycle %0d want %0d", acc_cyc, r1 + 1);
    end
    checks++;
    if (obs_wr() != exp_wr || obs_rsp() !== 8) begin
      errors++;
      $display("FAIL b2b_second: got '%s' t%0d want '%s' t8", obs_wr(), obs_rsp(), exp_wr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [1:0]  code = 2'($urandom);
      logic [31:0] ips = $urandom, ipd = $urandom;
      logic [23:0] ms = 24'($urandom), md = 24'($urandom);
      logic [15:0] ps = 16'($urandom), pd = 16'($urandom);
      logic [7:0]  id = 8'($urandom);
      logic [15:0] exp_ei;
      int np = $urandom_range(1, MAXP);
      done_on_poll = np; sl_err = 8'($urandom); sl_id = 8'($urandom); proto_err = 0;
      exp_ei = (code == 2'd0) ? 16'h0 : {sl_err, sl_id};
      model(code, ips, ipd, ms, md, ps, pd, id, np, 0);
      run_cmd(code, ips, ipd, ms, md, ps, pd, id, 0);
      checks++;
      if (obs_wr() != exp_wr) begin
        errors++; $display("FAIL rand%0d_writes: got '%s' want '%s'", n, obs_wr(), exp_wr);
      end
      checks++;
      if (obs_rd() != exp_rd) begin
        errors++; $display("FAIL rand%0d_reads: got '%s' want '%s'", n, obs_rd(), exp_rd);
      end
      checks++;
      if (obs_rsp() !== exp_rsp) begin
        errors++; $display("FAIL rand%0d_rsp_time: got %0d want %0d", n, obs_rsp(), exp_rsp);
      end
      checks++;
      if ({rsp_e_seen, rsp_i_seen} !== exp_ei || rsp_t_seen !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_rsp: got e%h i%h t%b want %h t0", n, rsp_e_seen, rsp_i_seen,
                 rsp_t_seen, exp_ei);
      end
      checks++;
      if (rsp_c.size() !== 1 || proto_err !== 0) begin
        errors++;
        $display("FAIL rand%0d_pulse_proto: got %0d/%0d want 1/0", n, rsp_c.size(), proto_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_ip_src = '0; cmd_ip_dst = '0;
    cmd_mac_src = '0; cmd_mac_dst = '0; cmd_port_src = '0; cmd_port_dst = '0; cmd_id = '0;
    test_reset();
    test_basic();
    test_error();
    test_reset_gap();
    test_load_only();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
